// File: rtl/nonrestoring_divider_if.sv
// Start/done handshake bundle shared by the divider and its requester.
// The requester drives start and the operands; the divider drives the status and results.
interface nonrestoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: radix-2 non-restoring division on operand magnitudes,
// one quotient bit per clock, then remainder correction and a sign fix-up.
module nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nonrestoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CALC    = 3'd2;
    localparam logic [2:0] S_CORRECT = 3'd3;
    localparam logic [2:0] S_SIGN    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH:0]     d_mag;
    logic [WIDTH+1:0]   p;
    logic [WIDTH-1:0]   q;
    logic               sa, sb;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   quo_r, rem_r;
    logic               dbz_r;

    logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH+1:0]   d_ext, p_sh, p_nx;

    // Magnitudes are WIDTH+1 bits so the most-negative operand is exact.
    always_comb begin
        a_ext = {a_reg[WIDTH-1], a_reg};
        b_ext = {b_reg[WIDTH-1], b_reg};
        a_mag = a_reg[WIDTH-1] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
        b_mag = b_reg[WIDTH-1] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
    end

    // The partial remainder can reach +/-2*|divisor| after the shift, hence WIDTH+2 bits.
    always_comb begin
        d_ext = {1'b0, d_mag};
        p_sh  = {p[WIDTH:0], q[WIDTH-1]};
        p_nx  = p[WIDTH+1] ? (p_sh + d_ext) : (p_sh - d_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            d_mag <= '0;
            p     <= '0;
            q     <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.dividend;
                        b_reg <= bus.divisor;
                        dbz_r <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (b_reg == '0) begin
                        quo_r <= '1;
                        rem_r <= a_reg;
                        dbz_r <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        q     <= a_mag[WIDTH-1:0];
                        d_mag <= b_mag;
                        sa    <= a_reg[WIDTH-1];
                        sb    <= b_reg[WIDTH-1];
                        p     <= '0;
                        cnt   <= CW'(WIDTH);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    p   <= p_nx;
                    q   <= {q[WIDTH-2:0], ~p_nx[WIDTH+1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_CORRECT;
                end
                S_CORRECT: begin
                    if (p[WIDTH+1])
                        p <= p + d_ext;
                    state <= S_SIGN;
                end
                S_SIGN: begin
                    // Negating a most-negative quotient wraps back onto itself.
                    quo_r <= (sa ^ sb) ? (~q + WIDTH'(1)) : q;
                    rem_r <= sa ? (~p[WIDTH-1:0] + WIDTH'(1)) : p[WIDTH-1:0];
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule
